// File: rtl/crc_stream_rx.sv
// -----------------------------------------------------------------------------
// crc_stream_rx
//
// Receive/check end of a serial CRC link. Codeword bits arrive MSB first
// (payload bits followed by KEY_W-1 CRC bits). The block divides the codeword
// by the generator polynomial as it streams in. It also keeps the raw bits so
// the payload can be handed out once the frame closes.
//
// Parameters
//   DATA_W  maximum payload width in bits
//   KEY_W   generator polynomial width (CRC field is KEY_W-1 bits)
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   key        generator polynomial, MSB = highest power (MSB implied 1)
//   s_valid    serial beat valid
//   s_ready    serial beat accepted when s_valid && s_ready
//   s_bit      codeword bit, MSB first
//   s_last     final codeword bit of the frame
//   m_valid    result valid, held until m_ready
//   m_ready    result consumed when m_valid && m_ready
//   m_data     recovered payload, right-aligned, zero-extended
//   m_len      payload bit count
//   m_err      CRC remainder nonzero
//   m_len_err  frame length out of range
//   m_rem      final remainder (only with CRC_STREAM_RX_REM_OUT_EN)
//
// Build option
//   CRC_STREAM_RX_REM_OUT_EN  adds the m_rem output port
// -----------------------------------------------------------------------------
module crc_stream_rx #(
   parameter int DATA_W = 32,
   parameter int KEY_W  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [KEY_W-1:0]             key,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic                         s_bit,
   input  logic                         s_last,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [DATA_W-1:0]            m_data,
   output logic [$clog2(DATA_W+1)-1:0]  m_len,
   output logic                         m_err,
   output logic                         m_len_err
`ifdef CRC_STREAM_RX_REM_OUT_EN
   ,output logic [KEY_W-2:0]            m_rem
`endif
);

   localparam int CW   = DATA_W + KEY_W - 1;     // longest legal codeword
   localparam int NMAX = DATA_W + KEY_W;         // beat counter saturation
   localparam int NW   = $clog2(NMAX + 1);
   localparam int LW   = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

   state_t            state;
   logic [KEY_W-2:0]  rem;
   logic [KEY_W-2:0]  key_q;
   logic [CW-1:0]     shreg;
   logic [NW-1:0]     n_cnt;

   logic              accept;
   logic              start;
   logic              fb;
   logic              len_ok;
   logic [KEY_W-2:0]  rem_base;
   logic [KEY_W-2:0]  rem_next;
   logic [KEY_W-2:0]  key_use;
   logic [CW-1:0]     shreg_base;
   logic [CW-1:0]     shreg_next;
   logic [NW-1:0]     n_base;
   logic [NW-1:0]     n_next;

   // The leading polynomial term is always 1, so the key MSB carries no
   // information and is deliberately left unused.
   logic key_msb_unused;
   assign key_msb_unused = key[KEY_W-1];

   // Next-state datapath for one accepted beat. In IDLE the frame is starting,
   // so the accumulators are taken as cleared and the live key is used.
   // NOTE: every always_comb output is assigned on every path; a missed
   // assignment would infer a latch.
   always_comb begin
      accept     = s_valid && s_ready;
      start      = (state == IDLE);
      rem_base   = start ? '0 : rem;
      shreg_base = start ? '0 : shreg;
      n_base     = start ? '0 : n_cnt;
      key_use    = start ? key[KEY_W-2:0] : key_q;
      fb         = rem_base[KEY_W-2];
      // Shift the new bit in, drop the x^(KEY_W-1) term and reduce by the key.
      rem_next   = (KEY_W-1)'({rem_base, s_bit}) ^ (fb ? key_use : '0);
      shreg_next = {shreg_base[CW-2:0], s_bit};
      n_next     = (n_base == NW'(NMAX)) ? n_base : n_base + NW'(1);
      len_ok     = (n_next >= NW'(KEY_W)) && (n_next <= NW'(CW));
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         s_ready   <= 1'b0;
         m_valid   <= 1'b0;
         m_data    <= '0;
         m_len     <= '0;
         m_err     <= 1'b0;
         m_len_err <= 1'b0;
`ifdef CRC_STREAM_RX_REM_OUT_EN
         m_rem     <= '0;
`endif
         rem       <= '0;
         key_q     <= '0;
         shreg     <= '0;
         n_cnt     <= '0;
      end else begin
         case (state)
            IDLE, RECV: begin
               s_ready <= 1'b1;
               if (accept) begin
                  rem   <= rem_next;
                  shreg <= shreg_next;
                  n_cnt <= n_next;
                  if (start) key_q <= key[KEY_W-2:0];
                  if (s_last) begin
                     // Result is registered here, so m_valid appears one
                     // cycle after the last beat.
                     state     <= DONE;
                     s_ready   <= 1'b0;
                     m_valid   <= 1'b1;
                     m_data    <= len_ok ? shreg_next[CW-1:KEY_W-1] : '0;
                     m_len     <= len_ok ? LW'(n_next - NW'(KEY_W-1)) : '0;
                     m_err     <= len_ok && (rem_next != '0);
                     m_len_err <= !len_ok;
`ifdef CRC_STREAM_RX_REM_OUT_EN
                     m_rem     <= len_ok ? rem_next : '0;
`endif
                  end else begin
                     state <= RECV;
                  end
               end
            end
            DONE: begin
               // s_ready stays low through the hand-off cycle; the next
               // frame can start one cycle later.
               if (m_ready) begin
                  state   <= IDLE;
                  s_ready <= 1'b1;
                  m_valid <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               s_ready <= 1'b0;
               m_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_crc_stream_rx.sv
// -----------------------------------------------------------------------------
// tb_crc_stream_rx
//
// Self-checking bench for crc_stream_rx (DATA_W=32, KEY_W=4). Expected results
// come from a long-division reference model. They are queued when a frame is
// driven and compared when the DUT presents its result.
// -----------------------------------------------------------------------------
module tb_crc_stream_rx;

   localparam int DATA_W = 32;
   localparam int KEY_W  = 4;

   typedef struct packed {
      logic [31:0] data;
      logic [5:0]  len;
      logic        err;
      logic        len_err;
      logic [2:0]  rem;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  key = 4'b1101;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        s_bit = 1'b0;
   logic        s_last = 1'b0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [31:0] m_data;
   logic [5:0]  m_len;
   logic        m_err;
   logic        m_len_err;
`ifdef CRC_STREAM_RX_REM_OUT_EN
   logic [2:0]  m_rem;
`endif

   int   pass_cnt  = 0;
   int   total_cnt = 0;
   exp_t sb_q[$];

   crc_stream_rx #(.DATA_W(DATA_W), .KEY_W(KEY_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .key       (key),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_bit     (s_bit),
      .s_last    (s_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_len     (m_len),
      .m_err     (m_err),
      .m_len_err (m_len_err)
`ifdef CRC_STREAM_RX_REM_OUT_EN
      ,.m_rem    (m_rem)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // Reference: plain polynomial long division of the whole codeword.
   function automatic exp_t model(input logic [63:0] cw, input int n, input logic [3:0] k);
      exp_t        e;
      logic [63:0] r;
      logic [3:0]  kf;
      e  = '0;
      kf = k | 4'b1000;
      if (n < KEY_W || n > DATA_W + KEY_W - 1) begin
         e.len_err = 1'b1;
      end else begin
         r = cw & ((64'd1 << n) - 64'd1);
         for (int i = n - 1; i >= KEY_W - 1; i--)
            if (r[i]) r = r ^ ({60'd0, kf} << (i - (KEY_W - 1)));
         e.rem  = r[2:0];
         e.err  = (r[2:0] != 3'd0);
         e.data = 32'(r >> 3) | 32'((cw & ((64'd1 << n) - 64'd1)) >> 3);
         e.len  = 6'(n - (KEY_W - 1));
      end
      return e;
   endfunction

   // Drives one codeword MSB first, queues its expected result and checks
   // that m_valid is up one cycle after the last beat.
   task automatic drive_frame(input logic [63:0] cw_in, input int n, input logic [3:0] k,
                              input bit key_wiggle, output int stalls);
      logic [63:0] cw;
      cw = (n >= 64) ? cw_in : (cw_in & ((64'd1 << n) - 64'd1));
      sb_q.push_back(model(cw, n, k));
      stalls = 0;
      key    = k;
      for (int i = n - 1; i >= 0; i--) begin
         int w;
         w       = 0;
         s_valid = 1'b1;
         s_bit   = cw[i];
         s_last  = (i == 0);
         while (s_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
         end
         if (w != 0) stalls++;
         if (s_ready !== 1'b1) begin
            total_cnt++;
            $display("FAIL beat_accept: s_ready=%b, expected 1 within 20 cycles", s_ready);
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
         end
         @(negedge clk);
         if (key_wiggle) key = 4'($urandom);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      total_cnt++;
      if (m_valid !== 1'b1)
         $display("FAIL latency: m_valid=%b one cycle after last beat, expected 1", m_valid);
      else
         pass_cnt++;
   endtask

   // Waits (bounded) for a result, compares it with the scoreboard head,
   // optionally holds m_ready low, then consumes it.
   task automatic check_result(input string name, input int hold);
      exp_t e;
      int   w;
      w = 0;
      while (m_valid !== 1'b1 && w < 10) begin
         @(negedge clk);
         w++;
      end
      e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
      total_cnt++;
      if (m_valid !== 1'b1) begin
         $display("FAIL %s_valid: m_valid=%b, expected 1", name, m_valid);
         return;
      end
      pass_cnt++;
      total_cnt++;
      if (m_data !== e.data) $display("FAIL %s_data: got %h, expected %h", name, m_data, e.data);
      else pass_cnt++;
      total_cnt++;
      if (m_len !== e.len) $display("FAIL %s_len: got %0d, expected %0d", name, m_len, e.len);
      else pass_cnt++;
      total_cnt++;
      if (m_err !== e.err) $display("FAIL %s_err: got %b, expected %b", name, m_err, e.err);
      else pass_cnt++;
      total_cnt++;
      if (m_len_err !== e.len_err)
         $display("FAIL %s_len_err: got %b, expected %b", name, m_len_err, e.len_err);
      else pass_cnt++;
`ifdef CRC_STREAM_RX_REM_OUT_EN
      total_cnt++;
      if (m_rem !== e.rem) $display("FAIL %s_rem: got %b, expected %b", name, m_rem, e.rem);
      else pass_cnt++;
`endif
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         total_cnt++;
         if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_data !== e.data || m_len !== e.len ||
             m_err !== e.err || m_len_err !== e.len_err)
            $display("FAIL %s_hold%0d: valid=%b ready=%b data=%h len=%0d, expected 1 0 %h %0d",
                     name, c, m_valid, s_ready, m_data, m_len, e.data, e.len);
         else
            pass_cnt++;
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      total_cnt++;
      if (m_valid !== 1'b0) $display("FAIL %s_consume: m_valid=%b, expected 0", name, m_valid);
      else pass_cnt++;
      total_cnt++;
      if (s_ready !== 1'b1) $display("FAIL %s_rearm: s_ready=%b, expected 1", name, s_ready);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total_cnt++;
      if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== 32'd0 || m_len !== 6'd0 ||
          m_err !== 1'b0 || m_len_err !== 1'b0)
         $display("FAIL reset_outputs: ready=%b valid=%b data=%h len=%0d err=%b lerr=%b, expected all 0",
                  s_ready, m_valid, m_data, m_len, m_err, m_len_err);
      else
         pass_cnt++;
      rst = 1'b0;
      total_cnt++;
      if (s_ready !== 1'b0) $display("FAIL reset_release: s_ready=%b, expected 0", s_ready);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (s_ready !== 1'b1) $display("FAIL reset_ready: s_ready=%b, expected 1", s_ready);
      else pass_cnt++;
   endtask

   task automatic test_good_frame();
      int st;
      drive_frame(64'b100100001, 9, 4'b1101, 1'b0, st);
      check_result("good", 0);
   endtask

   task automatic test_crc_error();
      int st;
      drive_frame(64'b100100011, 9, 4'b1101, 1'b0, st);
      check_result("crc_err", 0);
   endtask

   task automatic test_short_frames();
      int st;
      drive_frame(64'b101, 3, 4'b1101, 1'b0, st);
      check_result("short3", 0);
      drive_frame(64'b1, 1, 4'b1101, 1'b0, st);
      check_result("single", 0);
   endtask

   task automatic test_overlong();
      int st;
      drive_frame(64'd0, 36, 4'b1101, 1'b0, st);
      total_cnt++;
      if (st != 0) $display("FAIL overlong_ready: %0d stalled beats, expected 0", st);
      else pass_cnt++;
      check_result("overlong", 0);
   endtask

   task automatic test_length_bounds();
      int          st;
      logic [63:0] p;
      // Shortest legal frame: 1-bit payload.
      drive_frame(64'b1101, 4, 4'b1101, 1'b0, st);
      check_result("min_len", 0);
      // Longest legal frame: 32-bit payload with a correct CRC.
      p = 64'hDEADBEEF << 3;
      drive_frame(p | 64'(model(p, 35, 4'b1011).rem), 35, 4'b1011, 1'b0, st);
      check_result("max_len", 0);
   endtask

   task automatic test_backpressure();
      int st;
      drive_frame(64'b100100001, 9, 4'b1101, 1'b0, st);
      check_result("bp", 5);
   endtask

   task automatic test_reset_mid_frame();
      int          st;
      logic [63:0] cw;
      cw = 64'b100100001;
      key = 4'b1101;
      for (int i = 8; i > 4; i--) begin
         s_valid = 1'b1;
         s_bit   = cw[i];
         s_last  = 1'b0;
         @(negedge clk);
      end
      s_valid = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (m_valid !== 1'b0 || s_ready !== 1'b0)
         $display("FAIL midrst: m_valid=%b s_ready=%b, expected 0 0", m_valid, s_ready);
      else
         pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      drive_frame(cw, 9, 4'b1101, 1'b0, st);
      check_result("after_rst", 0);
   endtask

   // Random frames, mostly correct, some with a flipped bit, random key (MSB
   // ignored) and key scrambled mid-frame on alternate frames.
   task automatic test_back_to_back();
      int          st;
      int          len;
      logic [63:0] p;
      logic [63:0] cw;
      logic [3:0]  k;
      for (int t = 0; t < 10; t++) begin
         len = $urandom_range(1, 32);
         p   = {32'd0, 32'($urandom)} & ((64'd1 << len) - 64'd1);
         k   = 4'($urandom);
         cw  = (p << 3) | 64'(model(p << 3, len + 3, k).rem);
         if ($urandom_range(0, 2) == 0) cw = cw ^ (64'd1 << $urandom_range(0, len + 2));
         drive_frame(cw, len + 3, k, (t % 2) == 1, st);
         check_result("b2b", 0);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_crc_error();
      test_short_frames();
      test_overlong();
      test_length_bounds();
      test_backpressure();
      test_reset_mid_frame();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
